// File: rtl/partition_sweep_ctrl.sv
// Exhaustive sweep sequencer: walks pi through every pattern, compares exact vs approximate
// partition outputs, accumulates error metrics and streams approximate truth-table rows.
module partition_sweep_ctrl #(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int ERR_W   = NUM_IN + $clog2(NUM_OUT) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_IN-1:0]  pi,
    input  logic [NUM_OUT-1:0] po_exact,
    input  logic [NUM_OUT-1:0] po_approx,
    output logic               busy,
    output logic               done,
    output logic [NUM_IN:0]    mismatch_cnt,
    output logic [ERR_W-1:0]   bit_err_cnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_IN-1:0]  out_pattern,
    output logic [NUM_OUT-1:0] out_po,
    output logic               out_mismatch
);

    localparam int CNT_W = NUM_IN + 1;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        EMIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IN-1:0]  pi_q, pi_d;
    logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
    logic [ERR_W-1:0]   be_cnt_q, be_cnt_d;
    logic [NUM_OUT-1:0] out_po_q, out_po_d;
    logic               out_mm_q, out_mm_d;

    logic [NUM_OUT-1:0] diff;
    logic [ERR_W-1:0]   diff_pop;
    logic               row_mm;

    always_comb begin
        diff     = po_exact ^ po_approx;
        row_mm   = |diff;
        diff_pop = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            diff_pop = diff_pop + ERR_W'(diff[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        pi_d     = pi_q;
        mm_cnt_d = mm_cnt_q;
        be_cnt_d = be_cnt_q;
        out_po_d = out_po_q;
        out_mm_d = out_mm_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pi_d     = '0;
                    mm_cnt_d = '0;
                    be_cnt_d = '0;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                // pi has been stable a full cycle here, so both partitions have settled
                out_po_d = po_approx;
                out_mm_d = row_mm;
                mm_cnt_d = mm_cnt_q + CNT_W'(row_mm);
                be_cnt_d = be_cnt_q + diff_pop;
                state_d  = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (&pi_q) begin
                        state_d = DONE;
                    end else begin
                        pi_d    = pi_q + NUM_IN'(1);
                        state_d = SAMPLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pi_q     <= '0;
            mm_cnt_q <= '0;
            be_cnt_q <= '0;
            out_po_q <= '0;
            out_mm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pi_q     <= pi_d;
            mm_cnt_q <= mm_cnt_d;
            be_cnt_q <= be_cnt_d;
            out_po_q <= out_po_d;
            out_mm_q <= out_mm_d;
        end
    end

    assign pi           = pi_q;
    assign busy         = (state_q == SAMPLE) || (state_q == EMIT);
    assign done         = (state_q == DONE);
    assign out_valid    = (state_q == EMIT);
    assign out_pattern  = pi_q;
    assign out_po       = out_po_q;
    assign out_mismatch = out_mm_q;
    assign mismatch_cnt = mm_cnt_q;
    assign bit_err_cnt  = be_cnt_q;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Directed bench for partition_sweep_ctrl: table of sweep configurations plus
// hand-written reset and idle sequences.
module tb_partition_sweep_ctrl;

    localparam int NUM_IN  = 7;
    localparam int NUM_OUT = 4;
    localparam int ERR_W   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [NUM_IN-1:0]  pi;
    logic [NUM_OUT-1:0] po_exact;
    logic [NUM_OUT-1:0] po_approx;
    logic               busy;
    logic               done;
    logic [NUM_IN:0]    mismatch_cnt;
    logic [ERR_W-1:0]   bit_err_cnt;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_IN-1:0]  out_pattern;
    logic [NUM_OUT-1:0] out_po;
    logic               out_mismatch;

    partition_sweep_ctrl #(
        .NUM_IN (NUM_IN),
        .NUM_OUT(NUM_OUT),
        .ERR_W  (ERR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pi          (pi),
        .po_exact    (po_exact),
        .po_approx   (po_approx),
        .busy        (busy),
        .done        (done),
        .mismatch_cnt(mismatch_cnt),
        .bit_err_cnt (bit_err_cnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pattern (out_pattern),
        .out_po      (out_po),
        .out_mismatch(out_mismatch)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    // Partition models: 0 identical, 1 approx stuck at zero, 2 approx MSB flipped
    int mode = 0;

    function automatic logic [3:0] approx_of(input int m, input logic [6:0] p);
        case (m)
            0:       approx_of = p[3:0];
            1:       approx_of = 4'b0000;
            default: approx_of = p[3:0] ^ 4'b1000;
        endcase
    endfunction

    assign po_exact  = pi[3:0];
    assign po_approx = approx_of(mode, pi);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    typedef struct {
        int mode;
        int stall_pat;
        int stall_len;
        int start_at;
        int exp_mm;
        int exp_be;
        int exp_edges;
    } vec_t;

    vec_t vecs[5];

    task automatic run_sweep(input vec_t v);
        int e0, exp_pat, mm_acc, be_acc, mm_row, be_row, stalled, rows;
        bit finished, spurious_done;
        logic [6:0] p;
        logic [3:0] ex, ap;
        exp_pat = 0; mm_acc = 0; be_acc = 0; stalled = 0; rows = 0;
        finished = 0; spurious_done = 0;
        mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = edges;
        check("start_busy", int'(busy), 1);
        check("start_pi", int'(pi), 0);
        check("start_done", int'(done), 0);
        check("start_valid", int'(out_valid), 0);
        for (int c = 0; c < 1000 && !finished; c++) begin
            start = 1'b0;
            if (done) begin
                finished = 1;
            end else begin
                if (out_valid) begin
                    p  = 7'(exp_pat);
                    ex = p[3:0];
                    ap = approx_of(v.mode, p);
                    mm_row = mm_acc + int'(ex != ap);
                    be_row = be_acc + $countones(ex ^ ap);
                    check("row_pattern", int'(out_pattern), exp_pat);
                    check("row_po", int'(out_po), int'(ap));
                    check("row_mismatch", int'(out_mismatch), int'(ex != ap));
                    check("row_mm_cnt", int'(mismatch_cnt), mm_row);
                    check("row_be_cnt", int'(bit_err_cnt), be_row);
                    if (v.start_at >= 0 && !spurious_done && exp_pat == v.start_at) begin
                        start = 1'b1;
                        spurious_done = 1;
                    end
                    if (exp_pat == v.stall_pat && stalled < v.stall_len) begin
                        out_ready = 1'b0;
                        stalled++;
                    end else begin
                        out_ready = 1'b1;
                        mm_acc = mm_row;
                        be_acc = be_row;
                        exp_pat++;
                        rows++;
                    end
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", int'(finished), 1);
        check("done_edge", edges - e0, v.exp_edges);
        check("rows", rows, 128);
        check("final_mm_cnt", int'(mismatch_cnt), v.exp_mm);
        check("final_be_cnt", int'(bit_err_cnt), v.exp_be);
        check("final_busy", int'(busy), 0);
        check("final_valid", int'(out_valid), 0);
        check("final_pi", int'(pi), 127);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pi"}, int'(pi), 0);
        check({tag, "_mm"}, int'(mismatch_cnt), 0);
        check({tag, "_be"}, int'(bit_err_cnt), 0);
        check({tag, "_po"}, int'(out_po), 0);
        check({tag, "_omm"}, int'(out_mismatch), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("idle_hold");

        //        mode stall_pat stall_len start_at mm   be   edges
        vecs[0] = '{0,   -1,       0,        -1,      0,   0,   256};
        vecs[1] = '{1,   -1,       0,        -1,      120, 256, 256};
        vecs[2] = '{2,   -1,       0,        -1,      128, 128, 256};
        vecs[3] = '{0,   3,        5,        -1,      0,   0,   261};
        vecs[4] = '{1,   -1,       0,        40,      120, 256, 256};
        for (int i = 0; i < 5; i++) begin
            run_sweep(vecs[i]);
        end

        repeat (3) @(negedge clk);
        check("done_hold", int'(done), 1);
        check("done_hold_pi", int'(pi), 127);
        check("done_hold_mm", int'(mismatch_cnt), 120);

        // Reset in the middle of a sweep while row 50 is offered
        mode = 1;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (out_valid && out_pattern == 7'd50) hit = 1;
            else @(negedge clk);
        end
        check("mid_hit", int'(hit), 1);
        check("mid_mm_cnt", int'(mismatch_cnt), 47);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_rst");
        repeat (2) @(negedge clk);
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        run_sweep(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/partition_sweep_ctrl.md
# partition_sweep_ctrl

Sequencer for exhaustive evaluation of one approximated logic partition against its exact version. It steps a registered input pattern through all 2^NUM_IN values and drives it to both the exact and the approximate combinational partition. For each pattern it captures both outputs, accumulates mismatch and bit-error counts, and streams the approximate truth-table row out over a valid/ready channel. It replaces the free-running exhaustive testbench sweep with a synthesizable, backpressure-aware controller for on-chip error-metric collection.

## Interface
- NUM_IN, 7: partition input count; sweep length is 2^NUM_IN patterns.
- NUM_OUT, 4: partition output count.
- ERR_W, NUM_IN + $clog2(NUM_OUT) + 1: width of bit_err_cnt; holds 2^NUM_IN*NUM_OUT.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- pi  out  NUM_IN  registered pattern driven to both partitions.
- po_exact  in  NUM_OUT  exact partition output (combinational from pi).
- po_approx  in  NUM_OUT  approximate partition output (combinational from pi).
- busy  out  1  high in SAMPLE/EMIT.
- done  out  1  high in DONE; held until next start or rst.
- mismatch_cnt  out  NUM_IN+1  patterns with po_exact != po_approx.
- bit_err_cnt  out  ERR_W  total popcount(po_exact ^ po_approx).
- out_valid  out  1  truth-table row available.
- out_ready  in  1  consumer accepts row.
- out_pattern  out  NUM_IN  pattern of current row (equals pi).
- out_po  out  NUM_OUT  captured po_approx.
- out_mismatch  out  1  captured po_exact != po_approx.

## Operation
- States: IDLE, SAMPLE, EMIT, DONE.
- Reset values: state=IDLE, pi=0, mismatch_cnt=0, bit_err_cnt=0, out_po=0, out_mismatch=0, busy=0, done=0, out_valid=0.
- IDLE: on start, the block clears pi, mismatch_cnt and bit_err_cnt to 0 and moves to SAMPLE. Without start it holds.
- SAMPLE (one cycle), in which pi has been stable for at least one full cycle:
  - out_po <= po_approx; out_mismatch <= (po_exact != po_approx).
  - mismatch_cnt += out_mismatch term; bit_err_cnt += popcount(po_exact ^ po_approx).
  - Next state is EMIT.
- EMIT: out_valid=1.
  - Handshake (out_valid & out_ready): if pi is all-ones, go to DONE. Otherwise pi <= pi+1 and go to SAMPLE.
  - No handshake: hold all outputs and counters unchanged.
- DONE: done=1; counters, out_po and pi are frozen. start behaves as in IDLE: clear, pi=0, SAMPLE, done drops next cycle.
- start in SAMPLE or EMIT is ignored; a sweep cannot be restarted except by rst.
- Counters cannot saturate or wrap by construction: the worst case equals the width capacity minus margin.
- pi wraps never; the all-ones pattern terminates the sweep.
- rst mid-sweep returns everything to reset values on the next edge. No row is emitted for the interrupted pattern after reset.

## Timing
- start sampled at edge E0. Then:
  - busy=1 and pi=0 after E0.
  - Capture and count update occur at E1.
  - out_valid=1 during the cycle after E1.
- With out_ready tied high, each pattern takes 2 cycles. The last handshake is at E0+2·2^NUM_IN, and done=1 after it: edge 256 for NUM_IN=7.
- Each cycle of out_ready low in EMIT adds exactly one cycle. Row data is stable while out_valid=1 and unaccepted.
- Counters shown at a row's out_valid already include that row.
- out_valid and out_ready are independent: out_ready may be high before valid, and out_valid never depends combinationally on out_ready.

## Test plan
- Identical partitions (po_approx = po_exact = pi[3:0]), ready high → 128 rows with out_pattern 0..127 in order, out_mismatch=0 throughout, final mismatch_cnt=0, bit_err_cnt=0, done at edge 256.
- po_exact=pi[3:0], po_approx=4'b0000 → mismatch_cnt=120, bit_err_cnt=256; row for pattern 7'h05 shows out_po=0, out_mismatch=1.
- po_approx = po_exact ^ 4'b1000 → mismatch_cnt=128, bit_err_cnt=128; every out_mismatch=1.
- out_ready low for 5 cycles while out_pattern=3 → pattern 3 and counters held for those 5 cycles, no skipped or duplicated rows, done at edge 261.
- rst asserted while out_pattern=50 → all outputs return to reset values next cycle. A fresh start then yields pattern 0 first with cleared counters.
- start pulsed during a sweep → ignored, sweep completes normally. start in DONE → done drops, counters clear, sweep repeats with identical results.
